// File: rtl/cmul_rr_arbiter_if.sv
// rtl/cmul_rr_arbiter_if.sv - requester/result bus of the shared complex-multiply arbiter
interface cmul_rr_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 16
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic                     en;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*WIDTH-1:0] req_a_re;
    logic [NUM_REQ*WIDTH-1:0] req_a_img;
    logic [NUM_REQ*WIDTH-1:0] req_b_re;
    logic [NUM_REQ*WIDTH-1:0] req_b_img;
    logic                     res_valid;
    logic [ID_W-1:0]          res_id;
    logic [WIDTH-1:0]         res_re;
    logic [WIDTH-1:0]         res_img;
    logic                     busy;

    modport master (
        output en, req_valid, req_a_re, req_a_img, req_b_re, req_b_img,
        input  req_ready, res_valid, res_id, res_re, res_img, busy
    );

    modport slave (
        input  en, req_valid, req_a_re, req_a_img, req_b_re, req_b_img,
        output req_ready, res_valid, res_id, res_re, res_img, busy
    );
endinterface

// File: rtl/cmul_rr_arbiter.sv
// rtl/cmul_rr_arbiter.sv - round-robin shared two-stage complex multiplier
module cmul_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 16,
    parameter int SCALING = 8
) (
    input  logic             clk,
    input  logic             rst,
    cmul_rr_arbiter_if.slave bus
);
    localparam int ID_W = $clog2(NUM_REQ);
    localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] grant_id;
    logic [ID_W-1:0] scan_idx;
    logic            grant_any;

    logic signed [WIDTH-1:0] g_a_re, g_a_img, g_b_re, g_b_img;

    logic                    s1_valid;
    logic [ID_W-1:0]         s1_id;
    logic signed [WIDTH-1:0] s1_a_re, s1_a_img, s1_b_re, s1_b_img;

    logic signed [2*WIDTH-1:0] p1, p2, p3, p4;
    logic signed [2*WIDTH-1:0] q1, q2, q3, q4;
    logic [WIDTH-1:0]          re_next, img_next;

    logic             out_valid;
    logic [ID_W-1:0]  out_id;
    logic [WIDTH-1:0] out_re, out_img;

    // Scan from the pointer upward with wrap; iterating in reverse lets the nearest valid requester win.
    always_comb begin
        grant_any = 1'b0;
        grant_id  = '0;
        scan_idx  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            scan_idx = ID_W'((int'(ptr) + k) % NUM_REQ);
            if (bus.en && bus.req_valid[scan_idx]) begin
                grant_any = 1'b1;
                grant_id  = scan_idx;
            end
        end
    end

    assign bus.req_ready = grant_any ? (NUM_REQ'(1) << grant_id) : '0;

    assign g_a_re  = bus.req_a_re [int'(grant_id)*WIDTH +: WIDTH];
    assign g_a_img = bus.req_a_img[int'(grant_id)*WIDTH +: WIDTH];
    assign g_b_re  = bus.req_b_re [int'(grant_id)*WIDTH +: WIDTH];
    assign g_b_img = bus.req_b_img[int'(grant_id)*WIDTH +: WIDTH];

    // Stage 1: capture the granted operands and advance the pointer past the winner.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr      <= '0;
            s1_valid <= 1'b0;
            s1_id    <= '0;
            s1_a_re  <= '0;
            s1_a_img <= '0;
            s1_b_re  <= '0;
            s1_b_img <= '0;
        end else begin
            s1_valid <= grant_any;
            if (grant_any) begin
                s1_id    <= grant_id;
                s1_a_re  <= g_a_re;
                s1_a_img <= g_a_img;
                s1_b_re  <= g_b_re;
                s1_b_img <= g_b_img;
                ptr      <= (grant_id == LAST_ID) ? '0 : grant_id + ID_W'(1);
            end
        end
    end

    // Full-width signed products, floor-scaled, then truncated and combined with wrap-around.
    assign p1 = (2*WIDTH)'(s1_a_re)  * (2*WIDTH)'(s1_b_re);
    assign p2 = (2*WIDTH)'(s1_a_img) * (2*WIDTH)'(s1_b_img);
    assign p3 = (2*WIDTH)'(s1_a_re)  * (2*WIDTH)'(s1_b_img);
    assign p4 = (2*WIDTH)'(s1_a_img) * (2*WIDTH)'(s1_b_re);
    assign q1 = p1 >>> SCALING;
    assign q2 = p2 >>> SCALING;
    assign q3 = p3 >>> SCALING;
    assign q4 = p4 >>> SCALING;
    assign re_next  = q1[WIDTH-1:0] - q2[WIDTH-1:0];
    assign img_next = q3[WIDTH-1:0] + q4[WIDTH-1:0];

    // Stage 2: register the result; data holds between valid pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_id    <= '0;
            out_re    <= '0;
            out_img   <= '0;
        end else begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_id  <= s1_id;
                out_re  <= re_next;
                out_img <= img_next;
            end
        end
    end

    assign bus.res_valid = out_valid;
    assign bus.res_id    = out_id;
    assign bus.res_re    = out_re;
    assign bus.res_img   = out_img;
    assign bus.busy      = s1_valid | out_valid;
endmodule

// File: tb/tb_cmul_rr_arbiter.sv
// tb/tb_cmul_rr_arbiter.sv - directed self-checking bench for cmul_rr_arbiter
module tb_cmul_rr_arbiter;
    localparam int N = 4;
    localparam int W = 16;

    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    cmul_rr_arbiter_if #(.NUM_REQ(N), .WIDTH(W)) bus ();

    cmul_rr_arbiter #(.NUM_REQ(N), .WIDTH(W), .SCALING(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input int i, input logic [15:0] ar, input logic [15:0] ai,
                           input logic [15:0] br, input logic [15:0] bi);
        bus.req_a_re [i*W +: W] = ar;
        bus.req_a_img[i*W +: W] = ai;
        bus.req_b_re [i*W +: W] = br;
        bus.req_b_img[i*W +: W] = bi;
    endtask

    initial begin
        rst           = 1'b1;
        bus.en        = 1'b1;
        bus.req_valid = '0;
        bus.req_a_re  = '0;
        bus.req_a_img = '0;
        bus.req_b_re  = '0;
        bus.req_b_img = '0;
        tick();
        tick();
        check("rst_res_valid", bus.res_valid, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_ready", bus.req_ready, 0);
        check("rst_res_id", bus.res_id, 0);
        check("rst_res_re", bus.res_re, 0);
        check("rst_res_img", bus.res_img, 0);
        rst = 1'b0;

        // single op from requester 0, latency and busy profile
        set_ops(0, 16'd256, 16'd0, 16'd256, 16'd256);
        bus.req_valid = 4'b0001;
        #1 check("t1_ready", bus.req_ready, 4'b0001);
        tick();
        bus.req_valid = '0;
        check("t1_busy_s1", bus.busy, 1);
        check("t1_valid_early", bus.res_valid, 0);
        tick();
        check("t1_valid", bus.res_valid, 1);
        check("t1_id", bus.res_id, 0);
        check("t1_re", bus.res_re, 16'd256);
        check("t1_img", bus.res_img, 16'd256);
        check("t1_busy_s2", bus.busy, 1);
        tick();
        check("t1_valid_end", bus.res_valid, 0);
        check("t1_busy_end", bus.busy, 0);
        check("t1_hold_re", bus.res_re, 16'd256);

        // requester 2, pointer now at 1
        set_ops(2, 16'd256, 16'd256, 16'd256, 16'hFF00);
        bus.req_valid = 4'b0100;
        #1 check("t2_ready", bus.req_ready, 4'b0100);
        tick();
        bus.req_valid = '0;
        tick();
        check("t2_valid", bus.res_valid, 1);
        check("t2_id", bus.res_id, 2);
        check("t2_re", bus.res_re, 16'd512);
        check("t2_img", bus.res_img, 16'd0);

        // floor shift of a small negative product
        set_ops(2, 16'hFFFF, 16'd0, 16'd1, 16'd0);
        bus.req_valid = 4'b0100;
        #1 check("t2b_ready", bus.req_ready, 4'b0100);
        tick();
        bus.req_valid = '0;
        tick();
        check("t2b_re", bus.res_re, 16'hFFFF);
        check("t2b_img", bus.res_img, 16'd0);

        // overflow and wrap, requester 3 (pointer at 3)
        set_ops(3, 16'd32767, 16'h8000, 16'd32767, 16'd32767);
        bus.req_valid = 4'b1000;
        #1 check("t4_ready", bus.req_ready, 4'b1000);
        tick();
        bus.req_valid = '0;
        tick();
        check("t4_id", bus.res_id, 3);
        check("t4_re", bus.res_re, 16'hFE80);
        check("t4_img", bus.res_img, 16'hFF80);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;

        // all four contending for eight cycles
        for (int i = 0; i < N; i++) set_ops(i, 16'(256 * (i + 1)), 16'd0, 16'd256, 16'd0);
        bus.req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            #1;
            check($sformatf("t3_ready_%0d", k), bus.req_ready, 1 << (k % 4));
            check($sformatf("t3_valid_%0d", k), bus.res_valid, (k >= 2) ? 1 : 0);
            if (k >= 2) begin
                check($sformatf("t3_id_%0d", k), bus.res_id, (k - 2) % 4);
                check($sformatf("t3_re_%0d", k), bus.res_re, 256 * ((k - 2) % 4 + 1));
            end
            tick();
        end
        bus.req_valid = '0;
        check("t3_valid_8", bus.res_valid, 1);
        check("t3_id_8", bus.res_id, 2);
        tick();
        check("t3_valid_9", bus.res_valid, 1);
        check("t3_id_9", bus.res_id, 3);
        check("t3_re_9", bus.res_re, 16'd1024);
        tick();
        check("t3_valid_10", bus.res_valid, 0);

        // enable low blocks grants; pointer frozen while disabled
        bus.en        = 1'b0;
        bus.req_valid = 4'b1111;
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("t5_ready_off_%0d", k), bus.req_ready, 0);
            check($sformatf("t5_valid_off_%0d", k), bus.res_valid, 0);
            tick();
        end
        bus.en        = 1'b1;
        bus.req_valid = 4'b0010;
        #1 check("t5_ready_1", bus.req_ready, 4'b0010);
        tick();
        bus.en        = 1'b0;
        bus.req_valid = 4'b1111;
        #1 check("t5_ready_off_a", bus.req_ready, 0);
        tick();
        check("t5_drain_valid", bus.res_valid, 1);
        check("t5_drain_id", bus.res_id, 1);
        check("t5_drain_re", bus.res_re, 16'd512);
        check("t5_ready_off_b", bus.req_ready, 0);
        tick();
        check("t5_drain_done", bus.res_valid, 0);
        bus.en = 1'b1;
        #1 check("t5_ready_2", bus.req_ready, 4'b0100);
        tick();
        bus.req_valid = '0;
        tick();
        check("t5_valid_2", bus.res_valid, 1);
        check("t5_id_2", bus.res_id, 2);
        check("t5_re_2", bus.res_re, 16'd768);
        tick();

        // reset right after a grant discards the op
        bus.req_valid = 4'b0010;
        #1 check("t6_ready", bus.req_ready, 4'b0010);
        tick();
        bus.req_valid = '0;
        rst           = 1'b1;
        tick();
        check("t6_valid_rst", bus.res_valid, 0);
        check("t6_busy_rst", bus.busy, 0);
        check("t6_id_rst", bus.res_id, 0);
        check("t6_re_rst", bus.res_re, 0);
        check("t6_img_rst", bus.res_img, 0);
        rst = 1'b0;
        tick();
        check("t6_valid_after", bus.res_valid, 0);
        check("t6_busy_after", bus.busy, 0);
        bus.req_valid = 4'b1111;
        #1 check("t6_ready_ptr0", bus.req_ready, 4'b0001);
        tick();
        bus.req_valid = '0;
        tick();
        check("t6_id_new", bus.res_id, 0);
        check("t6_re_new", bus.res_re, 16'd256);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
